sq_scheduler: RTL and testbench
===============================

# sq_scheduler

Submission/completion queue scheduler for the RDMA IP-encapsulator path. It watches the SQ tail doorbell and fetches one descriptor at a time from the shared descriptor BRAM. It streams the descriptor words to the datapath, waits for the datapath's completion, and writes a completion entry into the CQ ring. It then advances SQ head and CQ tail and requests an interrupt; the register block supplies base/doorbells and consumes head/tail/irq/error.

## Interface

Parameters
- QUEUE_DEPTH, 16: entries per ring; power of two, 2..256; IDX_W = log2(QUEUE_DEPTH).
- DESC_WORDS, 4: 32-bit words per SQ descriptor; 1..8.

Ports
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- enable_in  in  1  scheduler enable (CONTROL[0]).
- bram_base_in  in  32  byte base of the SQ ring.
- sq_tail_in  in  32  SQ tail doorbell (producer index).
- cq_head_in  in  32  CQ head (consumer index, host-written).
- sq_head_out  out  32  SQ head; zero-extended IDX_W index.
- cq_tail_out  out  32  CQ tail; zero-extended IDX_W index.
- bram_en_out  out  1  BRAM read enable.
- bram_we_out  out  1  BRAM write enable (CQ entry).
- bram_addr_out  out  32  BRAM byte address.
- bram_wdata_out  out  32  CQ entry data.
- bram_rdata_in  in  32  read data, valid exactly 1 cycle after bram_en_out.
- m_desc_data  out  32  descriptor word to datapath.
- m_desc_valid  out  1  descriptor word valid.
- m_desc_last  out  1  final word of the descriptor.
- m_desc_ready  in  1  datapath accepts word.
- cmpl_valid_in  in  1  datapath completion pulse.
- cmpl_status_in  in  8  completion status.
- irq_req_out  out  1  one-cycle interrupt request.
- lookup_error_out  out  1  one-cycle pulse: illegal doorbell index.
- busy_out  out  1  high in any state except IDLE.

## Operation

- Address map:
  - SQ entry i, word w: bram_base_in + (i*DESC_WORDS + w)*4.
  - CQ entry j: bram_base_in + QUEUE_DEPTH*DESC_WORDS*4 + j*4.
  - All 32-bit arithmetic wraps modulo 2^32.
- Indices: sq_head, cq_tail are IDX_W-bit registers, increment modulo QUEUE_DEPTH.
- Ring conditions:
  - SQ empty: sq_head == sq_tail_in[IDX_W-1:0].
  - CQ full: (cq_tail+1) mod QUEUE_DEPTH == cq_head_in[IDX_W-1:0].
- Doorbell check: sq_tail_in >= QUEUE_DEPTH or cq_head_in >= QUEUE_DEPTH is illegal.
  - Checked only in IDLE; pulses lookup_error_out for one cycle, once per change of the offending value.
  - While illegal, no fetch starts.
- States: IDLE, FETCH, RDWAIT, STREAM, WAIT_CMPL, CQ_WAIT, CQ_WRITE.
  - IDLE -> FETCH: enable_in & SQ not empty & doorbells legal. Word counter w = 0.
  - FETCH: bram_en_out=1, addr = SQ entry sq_head word w. Go to RDWAIT.
  - RDWAIT: capture bram_rdata_in into m_desc_data, set m_desc_valid, m_desc_last = (w == DESC_WORDS-1). Go to STREAM.
  - STREAM: hold the word until m_desc_ready.
    - On handshake, not last: w+1, go to FETCH.
    - On handshake, last: go to WAIT_CMPL.
  - WAIT_CMPL: on cmpl_valid_in, latch cmpl_status_in. Go to CQ_WAIT.
    - cmpl_valid_in outside WAIT_CMPL is ignored.
  - CQ_WAIT: stall while CQ full; otherwise go to CQ_WRITE.
  - CQ_WRITE: one cycle with bram_we_out=1, addr = CQ entry cq_tail.
    - wdata = {status[7:0], 8'h00, 8'h00, sq_head[7:0]} (sq_head zero-padded to 8 bits).
    - Same edge: sq_head+1, cq_tail+1, irq_req_out pulses the following cycle. Go to IDLE.
- enable_in is sampled only in IDLE. Deassertion mid-descriptor completes the full descriptor including the CQ write.
- bram_en_out and bram_we_out are never high together.
- sq_tail_in changes during processing are tolerated. Emptiness is re-evaluated only in IDLE.

## Timing

- Reset (async assert, sync release): state IDLE. All outputs 0, including sq_head_out, cq_tail_out, bram_addr_out, m_desc_data, irq_req_out and busy_out.
- Reset mid-operation aborts instantly: no CQ write and no irq; indices return to 0.
- Doorbell to first bram_en_out: sq_tail_in updated before edge N puts FETCH in cycle N+1.
- Per word: FETCH, RDWAIT, then at least one STREAM cycle. First m_desc_valid appears 2 cycles after FETCH.
- With m_desc_ready held high, a descriptor streams in 3*DESC_WORDS cycles.
- CQ_WRITE occurs at least 2 cycles after cmpl_valid_in (WAIT_CMPL->CQ_WAIT->CQ_WRITE).
- sq_head_out and cq_tail_out update on the edge ending CQ_WRITE. irq_req_out is high exactly the next cycle.
- Back-to-back descriptors: IDLE lasts one cycle between them.
- m_desc_valid never drops before its handshake; m_desc_data stays stable while valid.

## Test plan

- Single descriptor (DESC_WORDS=4, base 0x1000):
  - Stimulus: sq_tail_in=1, ready high, cmpl status 0x5A.
  - Response: reads at 0x1000..0x100C; 4 words streamed with last on the 4th; CQ write to 0x1100 with data 0x5A000000.
  - Then sq_head_out=1, cq_tail_out=1, one irq_req_out pulse.
- SQ wrap:
  - Stimulus: QUEUE_DEPTH=16, head preloaded to 15 by processing 15 descriptors, then sq_tail_in=1.
  - Response: 2 descriptors processed (entries 15, 0); sq_head_out=1; cq_tail wraps to 1.
- CQ full:
  - Stimulus: cq_head_in=0, 15 completions posted, 16th descriptor completes.
  - Response: stalls in CQ_WAIT with no bram_we_out.
  - Then cq_head_in=1: write to CQ entry 15 follows within 2 cycles.
- Backpressure:
  - Stimulus: m_desc_ready toggled randomly.
  - Response: each word is held stable until accepted, in order, no duplicates; last asserted only on word 3.
- Illegal doorbell:
  - Stimulus: sq_tail_in=0x20 with QUEUE_DEPTH=16.
  - Response: one lookup_error_out pulse, busy_out stays 0, no BRAM access.
  - Then sq_tail_in=2 processes 2 descriptors.
- Disable and reset mid-op:
  - Stimulus: drop enable_in during word 2.
  - Response: descriptor completes, then idle with the second pending descriptor untouched.
  - Stimulus: assert rstn=0 in WAIT_CMPL.
  - Response: all outputs 0 immediately, no irq.

Source files
------------

// File: rtl/sq_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sq_scheduler_if
// Description : Bus bundle between the SQ/CQ scheduler and its neighbours:
//               the shared descriptor BRAM port, the descriptor stream
//               towards the datapath and the datapath completion strobe.
//               master = scheduler side, slave = BRAM/datapath side.
// Ports       : bram_en_out/bram_we_out/bram_addr_out/bram_wdata_out (master out)
//               bram_rdata_in                                      (master in)
//               m_desc_data/m_desc_valid/m_desc_last               (master out)
//               m_desc_ready                                       (master in)
//               cmpl_valid_in/cmpl_status_in                       (master in)
// Revision    : 1.0 - initial release
// ============================================================================
interface sq_scheduler_if;
    logic        bram_en_out;
    logic        bram_we_out;
    logic [31:0] bram_addr_out;
    logic [31:0] bram_wdata_out;
    logic [31:0] bram_rdata_in;
    logic [31:0] m_desc_data;
    logic        m_desc_valid;
    logic        m_desc_last;
    logic        m_desc_ready;
    logic        cmpl_valid_in;
    logic [7:0]  cmpl_status_in;

    modport master (
        output bram_en_out, bram_we_out, bram_addr_out, bram_wdata_out,
        output m_desc_data, m_desc_valid, m_desc_last,
        input  bram_rdata_in, m_desc_ready, cmpl_valid_in, cmpl_status_in
    );

    modport slave (
        input  bram_en_out, bram_we_out, bram_addr_out, bram_wdata_out,
        input  m_desc_data, m_desc_valid, m_desc_last,
        output bram_rdata_in, m_desc_ready, cmpl_valid_in, cmpl_status_in
    );
endinterface
`default_nettype wire

// File: rtl/sq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sq_scheduler
// Description : Submission/completion queue scheduler. Fetches one SQ
//               descriptor at a time from the shared BRAM, streams its words
//               to the datapath, waits for the completion, writes a CQ entry,
//               then advances SQ head / CQ tail and raises an interrupt.
// Ports       : clk              - clock
//               rstn             - asynchronous active-low reset
//               enable_in        - scheduler enable (sampled in IDLE only)
//               bram_base_in     - byte base of the SQ ring (CQ ring follows)
//               sq_tail_in       - SQ producer doorbell
//               cq_head_in       - CQ consumer index
//               sq_head_out      - SQ head, zero-extended
//               cq_tail_out      - CQ tail, zero-extended
//               irq_req_out      - one-cycle interrupt request
//               lookup_error_out - one-cycle pulse on an illegal doorbell
//               busy_out         - high whenever the FSM is not IDLE
//               bus              - BRAM port, descriptor stream, completion
// Revision    : 1.0 - initial release
// ============================================================================
module sq_scheduler #(
    parameter int QUEUE_DEPTH = 16,
    parameter int DESC_WORDS  = 4
) (
    input  wire          clk,
    input  wire          rstn,
    input  wire          enable_in,
    input  wire  [31:0]  bram_base_in,
    input  wire  [31:0]  sq_tail_in,
    input  wire  [31:0]  cq_head_in,
    output logic [31:0]  sq_head_out,
    output logic [31:0]  cq_tail_out,
    output logic         irq_req_out,
    output logic         lookup_error_out,
    output logic         busy_out,
    sq_scheduler_if.master bus
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);

    // The CQ ring sits directly after the SQ ring in the same BRAM.
    localparam logic [31:0]      c_cq_offset = 32'(QUEUE_DEPTH * DESC_WORDS * 4);
    localparam logic [3:0]       c_last_word = 4'(DESC_WORDS - 1);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_RDWAIT    = 3'd2,
        S_STREAM    = 3'd3,
        S_WAIT_CMPL = 3'd4,
        S_CQ_WAIT   = 3'd5,
        S_CQ_WRITE  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [IDX_W-1:0]  r_sq_head;
    logic [IDX_W-1:0]  r_cq_tail;
    logic [3:0]        r_word;
    logic [31:0]       r_desc_data;
    logic              r_desc_last;
    logic [7:0]        r_status;
    logic              r_irq;
    logic              r_lookup_err;

    // Last offending doorbell value already reported, per doorbell.
    logic              r_sq_bad_vld;
    logic [31:0]       r_sq_bad_val;
    logic              r_cq_bad_vld;
    logic [31:0]       r_cq_bad_val;

    logic              w_sq_empty;
    logic [IDX_W-1:0]  w_cq_tail_inc;
    logic              w_cq_full;
    logic              w_sq_bad;
    logic              w_cq_bad;
    logic              w_db_legal;
    logic              w_sq_new_err;
    logic              w_cq_new_err;
    logic              w_word_last;
    logic [31:0]       w_sq_word_idx;
    logic [31:0]       w_sq_addr;
    logic [31:0]       w_cq_addr;

    // ------------------------------------------------------------------
    // Ring status and doorbell legality
    // ------------------------------------------------------------------
    assign w_sq_empty    = (r_sq_head == sq_tail_in[IDX_W-1:0]);
    assign w_cq_tail_inc = r_cq_tail + c_idx_one;   // power-of-two depth wraps for free
    assign w_cq_full     = (w_cq_tail_inc == cq_head_in[IDX_W-1:0]);

    assign w_sq_bad      = (sq_tail_in >= 32'(QUEUE_DEPTH));
    assign w_cq_bad      = (cq_head_in >= 32'(QUEUE_DEPTH));
    assign w_db_legal    = !w_sq_bad && !w_cq_bad;

    // Report an illegal doorbell once; report again only if its value moves.
    assign w_sq_new_err  = w_sq_bad && (!r_sq_bad_vld || (sq_tail_in != r_sq_bad_val));
    assign w_cq_new_err  = w_cq_bad && (!r_cq_bad_vld || (cq_head_in != r_cq_bad_val));

    assign w_word_last   = (r_word == c_last_word);

    // ------------------------------------------------------------------
    // Address generation (all arithmetic wraps modulo 2^32)
    // ------------------------------------------------------------------
    assign w_sq_word_idx = (32'(r_sq_head) * 32'(DESC_WORDS)) + 32'(r_word);
    assign w_sq_addr     = bram_base_in + (w_sq_word_idx << 2);
    assign w_cq_addr     = bram_base_in + c_cq_offset + (32'(r_cq_tail) << 2);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        bus.bram_en_out    = 1'b0;
        bus.bram_we_out    = 1'b0;
        bus.bram_addr_out  = 32'h0;
        bus.bram_wdata_out = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (enable_in && !w_sq_empty && w_db_legal) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.bram_en_out   = 1'b1;
                bus.bram_addr_out = w_sq_addr;
                w_state_nxt       = S_RDWAIT;
            end
            S_RDWAIT: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (bus.m_desc_ready) begin
                    w_state_nxt = w_word_last ? S_WAIT_CMPL : S_FETCH;
                end
            end
            S_WAIT_CMPL: begin
                if (bus.cmpl_valid_in) begin
                    w_state_nxt = S_CQ_WAIT;
                end
            end
            S_CQ_WAIT: begin
                if (!w_cq_full) begin
                    w_state_nxt = S_CQ_WRITE;
                end
            end
            S_CQ_WRITE: begin
                bus.bram_we_out    = 1'b1;
                bus.bram_addr_out  = w_cq_addr;
                bus.bram_wdata_out = {r_status, 16'h0000, 8'(r_sq_head)};
                w_state_nxt        = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sq_head    <= '0;
            r_cq_tail    <= '0;
            r_word       <= '0;
            r_desc_data  <= '0;
            r_desc_last  <= 1'b0;
            r_status     <= '0;
            r_irq        <= 1'b0;
            r_lookup_err <= 1'b0;
            r_sq_bad_vld <= 1'b0;
            r_sq_bad_val <= '0;
            r_cq_bad_vld <= 1'b0;
            r_cq_bad_val <= '0;
        end else begin
            // CQ_WRITE lasts exactly one cycle, so this is a one-cycle pulse.
            r_irq        <= (r_state == S_CQ_WRITE);
            r_lookup_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_word       <= '0;
                    r_lookup_err <= w_sq_new_err || w_cq_new_err;
                    r_sq_bad_vld <= w_sq_bad;
                    r_cq_bad_vld <= w_cq_bad;
                    if (w_sq_bad) begin
                        r_sq_bad_val <= sq_tail_in;
                    end
                    if (w_cq_bad) begin
                        r_cq_bad_val <= cq_head_in;
                    end
                end
                S_RDWAIT: begin
                    // Read data is valid exactly one cycle after the enable.
                    r_desc_data <= bus.bram_rdata_in;
                    r_desc_last <= w_word_last;
                end
                S_STREAM: begin
                    if (bus.m_desc_ready && !w_word_last) begin
                        r_word <= r_word + 4'd1;
                    end
                end
                S_WAIT_CMPL: begin
                    if (bus.cmpl_valid_in) begin
                        r_status <= bus.cmpl_status_in;
                    end
                end
                S_CQ_WRITE: begin
                    r_sq_head <= r_sq_head + c_idx_one;
                    r_cq_tail <= w_cq_tail_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.m_desc_data  = r_desc_data;
    assign bus.m_desc_valid = (r_state == S_STREAM);
    assign bus.m_desc_last  = (r_state == S_STREAM) && r_desc_last;

    assign sq_head_out      = 32'(r_sq_head);
    assign cq_tail_out      = 32'(r_cq_tail);
    assign irq_req_out      = r_irq;
    assign lookup_error_out = r_lookup_err;
    assign busy_out         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sq_scheduler
// Description : Self-checking bench for sq_scheduler. A queue-based ring
//               model predicts BRAM reads, streamed words and CQ writes; a
//               monitor pops and compares whatever the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sq_scheduler;
    localparam int QD = 16;
    localparam int DW = 4;
    localparam int NW = QD * DW;
    localparam int AW = $clog2(NW);

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable_in;
    logic [31:0] bram_base_in;
    logic [31:0] sq_tail_in;
    logic [31:0] cq_head_in;
    logic [31:0] sq_head_out;
    logic [31:0] cq_tail_out;
    logic        irq_req_out;
    logic        lookup_error_out;
    logic        busy_out;

    sq_scheduler_if bus();

    sq_scheduler #(.QUEUE_DEPTH(QD), .DESC_WORDS(DW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .enable_in        (enable_in),
        .bram_base_in     (bram_base_in),
        .sq_tail_in       (sq_tail_in),
        .cq_head_in       (cq_head_in),
        .sq_head_out      (sq_head_out),
        .cq_tail_out      (cq_tail_out),
        .irq_req_out      (irq_req_out),
        .lookup_error_out (lookup_error_out),
        .busy_out         (busy_out),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] sq_mem [NW];
    int          m_sq_head;
    int          m_cq_tail;
    logic [31:0] q_rd[$];
    logic [32:0] q_word[$];     // {last, data}
    logic [63:0] q_cq[$];       // {addr, data}
    logic [7:0]  q_status[$];

    int n_cmp, n_err;
    int hs_cnt, en_cnt, we_cnt, irq_cnt, lerr_cnt;
    logic [31:0] last_cq_addr, last_cq_data;
    bit ready_rand, no_cmpl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=event-occurred-or-missing required=model-behaviour", name);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - bram_base_in) >> 2;
        if (idx < 32'(NW)) return sq_mem[idx[AW-1:0]];
        return 32'hDEAD_BEEF;
    endfunction

    // Predict everything the DUT should do for the next n descriptors.
    task automatic push_batch(input int n, input int fixed_st);
        logic [7:0] st;
        for (int k = 0; k < n; k++) begin
            st = (fixed_st >= 0) ? 8'(fixed_st) : 8'($urandom_range(0, 255));
            for (int w = 0; w < DW; w++) begin
                q_rd.push_back(bram_base_in + 32'((m_sq_head * DW + w) * 4));
                q_word.push_back({(w == DW - 1), sq_mem[AW'(m_sq_head * DW + w)]});
            end
            q_status.push_back(st);
            q_cq.push_back({bram_base_in + 32'(QD * DW * 4) + 32'(m_cq_tail * 4),
                            st, 16'h0000, 8'(m_sq_head)});
            m_sq_head = (m_sq_head + 1) % QD;
            m_cq_tail = (m_cq_tail + 1) % QD;
        end
    endtask

    task automatic sync_drive();
        @(posedge clk);
        #2;
    endtask

    // Host consumes all completions, then rings the SQ doorbell for n entries.
    task automatic ring(input int n, input int fixed_st);
        sync_drive();
        cq_head_in = 32'(m_cq_tail);
        push_batch(n, fixed_st);
        sq_tail_in = 32'(m_sq_head);
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (cyc < 3000 && (q_rd.size() != 0 || q_word.size() != 0 ||
                                  q_cq.size() != 0 || busy_out));
        if (cyc >= 3000) fail({name, "_timeout"});
        @(negedge clk);
    endtask

    task automatic wait_words_drained(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 2000 && q_word.size() != 0) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) fail({name, "_timeout"});
    endtask

    task automatic monitor();
        logic        pv, phs, pwe;
        logic [31:0] pd;
        logic [32:0] ew;
        logic [63:0] ec;
        pv = 1'b0; phs = 1'b0; pwe = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 1'b0; phs = 1'b0; pwe = 1'b0;
                continue;
            end
            if (bus.bram_en_out && bus.bram_we_out) fail("en_we_overlap");
            if (bus.bram_en_out) begin
                en_cnt++;
                if (q_rd.size() == 0) fail("unexpected_read");
                else check("read_addr", bus.bram_addr_out, q_rd.pop_front());
            end
            if (bus.bram_we_out) begin
                we_cnt++;
                last_cq_addr = bus.bram_addr_out;
                last_cq_data = bus.bram_wdata_out;
                if (q_cq.size() == 0) fail("unexpected_cq_write");
                else begin
                    ec = q_cq.pop_front();
                    check("cq_addr", bus.bram_addr_out, ec[63:32]);
                    check("cq_data", bus.bram_wdata_out, ec[31:0]);
                end
            end
            if (pv && !phs) begin
                check("valid_held", 32'(bus.m_desc_valid), 32'd1);
                check("data_stable", bus.m_desc_data, pd);
            end
            if (bus.m_desc_valid && bus.m_desc_ready) begin
                hs_cnt++;
                if (q_word.size() == 0) fail("unexpected_word");
                else begin
                    ew = q_word.pop_front();
                    check("desc_data", bus.m_desc_data, ew[31:0]);
                    check("desc_last", 32'(bus.m_desc_last), 32'(ew[32]));
                end
            end
            if (pwe || irq_req_out) check("irq_timing", 32'(irq_req_out), 32'(pwe));
            if (irq_req_out) irq_cnt++;
            if (lookup_error_out) lerr_cnt++;
            pv  = bus.m_desc_valid;
            phs = bus.m_desc_valid && bus.m_desc_ready;
            pd  = bus.m_desc_data;
            pwe = bus.bram_we_out;
        end
    endtask

    // Read data appears exactly one cycle after the enable; otherwise garbage.
    task automatic mem_driver();
        logic        en_s;
        logic [31:0] a_s;
        forever begin
            @(negedge clk);
            en_s = bus.bram_en_out;
            a_s  = bus.bram_addr_out;
            @(posedge clk);
            #1;
            bus.bram_rdata_in = en_s ? mem_read(a_s) : $urandom;
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #2;
            bus.m_desc_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic cmpl_driver();
        int d;
        forever begin
            @(negedge clk);
            if (rstn && bus.m_desc_valid && bus.m_desc_ready) begin
                if (bus.m_desc_last) begin
                    if (!no_cmpl) begin
                        d = $urandom_range(0, 3);
                        @(posedge clk);
                        repeat (d) @(posedge clk);
                        #2;
                        bus.cmpl_valid_in  = 1'b1;
                        bus.cmpl_status_in = (q_status.size() != 0) ? q_status.pop_front() : 8'h00;
                        @(posedge clk);
                        #2;
                        bus.cmpl_valid_in  = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    // Stray completion while fetching: must be ignored.
                    @(posedge clk);
                    #2;
                    bus.cmpl_valid_in  = 1'b1;
                    bus.cmpl_status_in = 8'hEE;
                    @(posedge clk);
                    #2;
                    bus.cmpl_valid_in  = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int h0, i0, e0, w0, l0, busy_seen, found;

        n_cmp = 0; n_err = 0;
        hs_cnt = 0; en_cnt = 0; we_cnt = 0; irq_cnt = 0; lerr_cnt = 0;
        last_cq_addr = '0; last_cq_data = '0;
        ready_rand = 1'b0; no_cmpl = 1'b0;
        m_sq_head = 0; m_cq_tail = 0;
        rstn = 1'b0; enable_in = 1'b0;
        bram_base_in = 32'h0000_1000; sq_tail_in = '0; cq_head_in = '0;
        bus.m_desc_ready = 1'b0; bus.cmpl_valid_in = 1'b0;
        bus.cmpl_status_in = '0; bus.bram_rdata_in = '0;
        for (int i = 0; i < NW; i++) sq_mem[i] = $urandom;

        fork
            monitor();
            mem_driver();
            ready_driver();
            cmpl_driver();
        join_none

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_sq_head", sq_head_out, 32'd0);
        check("rst_cq_tail", cq_tail_out, 32'd0);
        check("rst_addr", bus.bram_addr_out, 32'd0);
        check("rst_desc_data", bus.m_desc_data, 32'd0);
        check("rst_irq", 32'(irq_req_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_bram_en", 32'(bus.bram_en_out), 32'd0);
        check("rst_desc_valid", 32'(bus.m_desc_valid), 32'd0);
        sync_drive();
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // ---------------- single descriptor ----------------
        sync_drive();
        enable_in  = 1'b1;
        cq_head_in = 32'd0;
        push_batch(1, 8'h5A);
        h0 = hs_cnt; i0 = irq_cnt;
        sq_tail_in = 32'd1;
        @(negedge clk);
        check("idle_before_doorbell_edge", 32'(busy_out), 32'd0);
        @(negedge clk);
        check("doorbell_to_fetch", 32'(bus.bram_en_out), 32'd1);
        check("first_read_addr", bus.bram_addr_out, 32'h0000_1000);
        repeat (2) @(negedge clk);
        check("first_valid_latency", 32'(bus.m_desc_valid), 32'd1);
        wait_done("single");
        check("single_cq_addr", last_cq_addr, 32'h0000_1100);
        check("single_cq_data", last_cq_data, 32'h5A00_0000);
        check("single_sq_head", sq_head_out, 32'd1);
        check("single_cq_tail", cq_tail_out, 32'd1);
        check("single_irq_count", 32'(irq_cnt - i0), 32'd1);
        check("single_words", 32'(hs_cnt - h0), 32'd4);

        // ---------------- backpressure, head up to 15 ----------------
        ready_rand = 1'b1;
        ring(5, -1);
        wait_done("bp_a");
        sync_drive();
        bram_base_in = 32'hFFFF_FFC0;   // ring straddles the 2^32 wrap
        ring(9, -1);
        wait_done("bp_b");
        check("bp_sq_head", sq_head_out, 32'd15);
        check("bp_cq_tail", cq_tail_out, 32'd15);

        // ---------------- SQ wrap ----------------
        ring(2, -1);
        wait_done("wrap");
        check("wrap_sq_head", sq_head_out, 32'd1);
        check("wrap_cq_tail", cq_tail_out, 32'd1);

        // ---------------- illegal doorbells ----------------
        ready_rand = 1'b0;
        sync_drive();
        l0 = lerr_cnt; e0 = en_cnt; w0 = we_cnt; busy_seen = 0;
        sq_tail_in = 32'h20;
        repeat (12) begin
            @(negedge clk);
            if (busy_out) busy_seen = 1;
        end
        check("illegal_sq_pulses", 32'(lerr_cnt - l0), 32'd1);
        check("illegal_busy", 32'(busy_seen), 32'd0);
        check("illegal_reads", 32'(en_cnt - e0), 32'd0);
        check("illegal_writes", 32'(we_cnt - w0), 32'd0);
        sync_drive();
        l0 = lerr_cnt;
        sq_tail_in = 32'h21;
        repeat (8) @(negedge clk);
        check("illegal_sq_change_pulses", 32'(lerr_cnt - l0), 32'd1);
        sync_drive();
        l0 = lerr_cnt;
        sq_tail_in = 32'(m_sq_head);
        cq_head_in = 32'h40;
        repeat (8) @(negedge clk);
        check("illegal_cq_pulses", 32'(lerr_cnt - l0), 32'd1);
        ring(2, -1);
        wait_done("after_illegal");
        check("after_illegal_sq_head", sq_head_out, 32'd3);

        // ---------------- CQ full ----------------
        ring(15, -1);
        wait_done("cq_fill");
        check("cq_fill_tail", cq_tail_out, 32'(m_cq_tail));
        sync_drive();
        w0 = we_cnt;
        push_batch(1, -1);
        sq_tail_in = 32'(m_sq_head);
        wait_words_drained("cq_full_stream");
        repeat (15) @(negedge clk);
        check("cq_full_no_write", 32'(we_cnt - w0), 32'd0);
        check("cq_full_busy", 32'(busy_out), 32'd1);
        sync_drive();
        cq_head_in = 32'((cq_head_in + 1) % QD);
        found = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.bram_we_out) found = 1;
        end
        check("cq_release_write", 32'(found), 32'd1);
        wait_done("cq_release");
        check("cq_release_tail", cq_tail_out, 32'(m_cq_tail));
        check("cq_release_sq_head", sq_head_out, 32'(m_sq_head));

        // ---------------- disable mid-descriptor ----------------
        sync_drive();
        cq_head_in = 32'(m_cq_tail);
        push_batch(1, -1);
        sq_tail_in = 32'((m_sq_head + 1) % QD);   // a second entry left pending
        h0 = hs_cnt;
        for (int c = 0; c < 200 && hs_cnt < h0 + 1; c++) @(negedge clk);
        sync_drive();
        enable_in = 1'b0;
        wait_done("disable");
        e0 = en_cnt; busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_out) busy_seen = 1;
        end
        check("disable_idle", 32'(busy_seen), 32'd0);
        check("disable_no_fetch", 32'(en_cnt - e0), 32'd0);
        check("disable_sq_head", sq_head_out, 32'(m_sq_head));

        // ---------------- reset in WAIT_CMPL ----------------
        no_cmpl = 1'b1;
        sync_drive();
        push_batch(1, -1);
        enable_in = 1'b1;
        wait_words_drained("reset_stream");
        repeat (3) @(negedge clk);
        check("wait_cmpl_busy", 32'(busy_out), 32'd1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_sq_head", sq_head_out, 32'd0);
        check("midrst_cq_tail", cq_tail_out, 32'd0);
        check("midrst_irq", 32'(irq_req_out), 32'd0);
        check("midrst_desc_data", bus.m_desc_data, 32'd0);
        check("midrst_we", 32'(bus.bram_we_out), 32'd0);
        q_rd.delete(); q_word.delete(); q_cq.delete(); q_status.delete();
        m_sq_head = 0; m_cq_tail = 0;
        enable_in = 1'b0; sq_tail_in = '0; cq_head_in = '0;
        i0 = irq_cnt; w0 = we_cnt;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        no_cmpl = 1'b0;
        repeat (10) @(negedge clk);
        check("postrst_irq", 32'(irq_cnt - i0), 32'd0);
        check("postrst_writes", 32'(we_cnt - w0), 32'd0);
        check("postrst_busy", 32'(busy_out), 32'd0);

        // ---------------- recovery ----------------
        sync_drive();
        enable_in = 1'b1;
        ready_rand = 1'b1;
        ring(3, -1);
        wait_done("recovery");
        check("recovery_sq_head", sq_head_out, 32'd3);
        check("recovery_cq_tail", cq_tail_out, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
